// File: rtl/gps_uart_rx.sv
// gps_uart_rx: 8N1 serial receiver for the GPS module's output.
// The raw line is double-synchronised. A mid-bit sampling FSM assembles
// each byte LSB first. Good bytes go to nmea_parse as a char/valid strobe.
// Bytes with a low stop bit are dropped, and frame_err pulses instead.
//
// Output handshake: valid is a one-cycle strobe with no ready. A byte is
// transferred on every cycle where valid is high, and char holds that byte
// from that cycle until the next strobe. The consumer must accept every
// strobe. frame_err is a one-cycle strobe that never coincides with valid.
// char does not change on a frame error.
module gps_uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] char,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Last count of a full bit period, and of half a bit (the start-bit centre).
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Fewer than 4 clocks per bit leaves no room to find the centre of a bit.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_ratio
      $error("gps_uart_rx: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t           st;
  logic             rx_meta;
  logic             rs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign dbg_state = st;

  // Two-flop synchroniser. Both flops reset to the idle (high) line level,
  // so leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

  // Receive FSM. The strobes, char and busy are all registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      char      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (st)
        IDLE: begin
          if (!rs) begin
            st   <= START;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!rs) begin
              st      <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // The line went high again before mid-bit, so this was a glitch.
              st   <= IDLE;
              busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt            <= '0;
            shift[bit_idx] <= rs;
            if (bit_idx == 3'd7) begin
              st <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rs) begin
              // Return to IDLE mid stop bit, so a start bit that follows
              // immediately is still caught.
              char  <= shift;
              valid <= 1'b1;
              st    <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              st        <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          // A held-low line (break) has to go high before another frame can start.
          if (rs) begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
